// File: rtl/mem_store_serializer.sv
// mem_store_serializer: memory stage that writes a 4-lane vector result
// into a single-port data memory one word per beat and feeds MEM/WB.
module mem_store_serializer #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWriteM,
    input  logic              memWriteM,
    input  logic [3:0]        RdM,
    input  logic [3:0]        compResOut,
    input  logic [31:0]       RD0,
    input  logic [31:0]       RD1,
    input  logic [31:0]       RD2,
    input  logic [31:0]       RD3,
    output logic              stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              regWriteW,
    output logic [3:0]        RdW,
    output logic [3:0]        compResW,
    output logic [31:0]       WD0,
    output logic [31:0]       WD1,
    output logic [31:0]       WD2,
    output logic [31:0]       WD3
);

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        FLUSH
    } state_t;

    typedef struct packed {
        logic         rw;
        logic         mw;
        logic [3:0]   rd;
        logic [3:0]   cmp;
        logic [127:0] data;
    } ins_t;

    state_t              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic                cap_rw_q, cap_rw_d;
    logic [3:0]          cap_rd_q, cap_rd_d;
    logic [3:0]          cap_cmp_q, cap_cmp_d;
    logic [127:0]        cap_data_q, cap_data_d;
    ins_t                skid0_q, skid0_d;
    ins_t                skid1_q, skid1_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                stall_q;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                wb_rw_q, wb_rw_d;
    logic [3:0]          wb_rd_q, wb_rd_d;
    logic [3:0]          wb_cmp_q, wb_cmp_d;
    logic [127:0]        wb_data_q, wb_data_d;

    ins_t in_w;
    ins_t cur;
    logic new_w;
    logic cur_v;
    logic pop;
    logic push;

    function automatic logic [31:0] lane(input logic [127:0] d,
                                         input logic [1:0]   b);
        return d[{b, 5'd0} +: 32];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [3:0] rd,
                                                  input logic [1:0] b);
        return ADDR_W'(BASE_ADDR) + ADDR_W'({rd, 2'b00}) + ADDR_W'(b);
    endfunction

    assign in_w  = '{rw: regWriteM, mw: memWriteM, rd: RdM,
                     cmp: compResOut, data: {RD3, RD2, RD1, RD0}};
    // Upstream only presents a fresh instruction after a non-stalled cycle.
    assign new_w = !stall_q;
    assign cur   = (cnt_q != 2'd0) ? skid0_q : in_w;
    assign cur_v = (cnt_q != 2'd0) || new_w;

    // Next-state, memory beat and MEM/WB load selection.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cap_rw_d    = cap_rw_q;
        cap_rd_d    = cap_rd_q;
        cap_cmp_d   = cap_cmp_q;
        cap_data_d  = cap_data_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_rw_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_cmp_d    = wb_cmp_q;
        wb_data_d   = wb_data_q;
        stall       = 1'b0;
        pop         = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                pop  = cnt_q != 2'd0;
                push = pop && new_w;
                if (cur_v && cur.mw) begin
                    stall       = 1'b1;
                    state_d     = STORE;
                    beat_d      = 2'd0;
                    cap_rw_d    = cur.rw;
                    cap_rd_d    = cur.rd;
                    cap_cmp_d   = cur.cmp;
                    cap_data_d  = cur.data;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_of(cur.rd, 2'd0);
                    mem_wdata_d = lane(cur.data, 2'd0);
                end else if (cur_v) begin
                    wb_rw_d   = cur.rw;
                    wb_rd_d   = cur.rd;
                    wb_cmp_d  = cur.cmp;
                    wb_data_d = cur.data;
                end
            end
            STORE: begin
                if (beat_q != 2'd3) begin
                    stall       = 1'b1;
                    beat_d      = beat_q + 2'd1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_of(cap_rd_q, beat_q + 2'd1);
                    mem_wdata_d = lane(cap_data_q, beat_q + 2'd1);
                end else begin
                    // Hold upstream one more cycle only if the skid is full
                    // and the flush cycle would otherwise overflow it.
                    stall   = cap_rw_q && (cnt_q == 2'd2);
                    state_d = cap_rw_q ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                wb_rw_d   = 1'b1;
                wb_rd_d   = cap_rd_q;
                wb_cmp_d  = cap_cmp_q;
                wb_data_d = cap_data_q;
                push      = new_w;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Skid FIFO: pop the head when it is consumed, append fresh input.
    always_comb begin
        skid0_d = skid0_q;
        skid1_d = skid1_q;
        cnt_d   = cnt_q;
        if (pop) begin
            skid0_d = skid1_q;
            cnt_d   = cnt_d - 2'd1;
        end
        if (push) begin
            if (cnt_d == 2'd0) begin
                skid0_d = in_w;
            end else begin
                skid1_d = in_w;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    // State, capture, skid, memory port and MEM/WB registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            cap_rw_q    <= 1'b0;
            cap_rd_q    <= 4'd0;
            cap_cmp_q   <= 4'd0;
            cap_data_q  <= '0;
            skid0_q     <= '0;
            skid1_q     <= '0;
            cnt_q       <= 2'd0;
            stall_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_rw_q     <= 1'b0;
            wb_rd_q     <= 4'd0;
            wb_cmp_q    <= 4'd0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cap_rw_q    <= cap_rw_d;
            cap_rd_q    <= cap_rd_d;
            cap_cmp_q   <= cap_cmp_d;
            cap_data_q  <= cap_data_d;
            skid0_q     <= skid0_d;
            skid1_q     <= skid1_d;
            cnt_q       <= cnt_d;
            stall_q     <= stall;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_rw_q     <= wb_rw_d;
            wb_rd_q     <= wb_rd_d;
            wb_cmp_q    <= wb_cmp_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign regWriteW = wb_rw_q;
    assign RdW       = wb_rd_q;
    assign compResW  = wb_cmp_q;
    assign WD0       = wb_data_q[31:0];
    assign WD1       = wb_data_q[63:32];
    assign WD2       = wb_data_q[95:64];
    assign WD3       = wb_data_q[127:96];

endmodule

// File: tb/tb_mem_store_serializer.sv
// tb_mem_store_serializer: randomized and directed stimulus with an
// in-order scoreboard for memory beats and writebacks.
module tb_mem_store_serializer;

    localparam int AW   = 6;
    localparam int BASE = 4;

    typedef struct packed {
        logic         rw;
        logic         mw;
        logic [3:0]   rd;
        logic [3:0]   cmp;
        logic [127:0] d;
    } ins_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } beat_t;

    typedef struct {
        logic [3:0]   rd;
        logic [3:0]   cmp;
        logic [127:0] d;
    } wb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          regWriteM = 1'b0;
    logic          memWriteM = 1'b0;
    logic [3:0]    RdM = '0;
    logic [3:0]    compResOut = '0;
    logic [31:0]   RD0 = '0, RD1 = '0, RD2 = '0, RD3 = '0;
    logic          stall, mem_we, regWriteW;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, WD0, WD1, WD2, WD3;
    logic [3:0]    RdW, compResW;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    beat_t mq[$];
    wb_t   wq[$];

    mem_store_serializer #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .regWriteM(regWriteM), .memWriteM(memWriteM),
        .RdM(RdM), .compResOut(compResOut),
        .RD0(RD0), .RD1(RD1), .RD2(RD2), .RD3(RD3),
        .stall(stall), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .regWriteW(regWriteW), .RdW(RdW), .compResW(compResW),
        .WD0(WD0), .WD1(WD1), .WD2(WD2), .WD3(WD3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input ins_t x);
        regWriteM  = x.rw;
        memWriteM  = x.mw;
        RdM        = x.rd;
        compResOut = x.cmp;
        RD0 = x.d[31:0];
        RD1 = x.d[63:32];
        RD2 = x.d[95:64];
        RD3 = x.d[127:96];
    endtask

    // Reference: a store writes its 4 lanes to consecutive wrapped
    // addresses; a register write produces one writeback, in order.
    task automatic model(input ins_t x);
        beat_t b;
        wb_t   w;
        if (x.mw) begin
            for (int i = 0; i < 4; i++) begin
                b.a = AW'((BASE + int'(x.rd) * 4 + i) % (1 << AW));
                b.d = x.d[32*i +: 32];
                mq.push_back(b);
            end
        end
        if (x.rw) begin
            w.rd  = x.rd;
            w.cmp = x.cmp;
            w.d   = x.d;
            wq.push_back(w);
        end
    endtask

    // Present x until the DUT releases stall; n = cycles it was held.
    task automatic issue(input ins_t x, input bit use_model, output int n);
        logic s;
        n = 0;
        drive(x);
        if (use_model) model(x);
        do begin
            @(negedge clk);
            s = stall;
            @(posedge clk);
            #1;
            n++;
        end while (s && n < 20);
        if (s) begin
            checks++;
            failures++;
            $display("FAIL stall_timeout actual=1 required=0");
        end
    endtask

    function automatic ins_t mk(input bit rw, input bit mw,
                                input logic [3:0] rd, input logic [3:0] cmp,
                                input logic [127:0] d);
        ins_t x;
        x.rw  = rw;
        x.mw  = mw;
        x.rd  = rd;
        x.cmp = cmp;
        x.d   = d;
        return x;
    endfunction

    task automatic do_reset();
        mon_en = 1'b0;
        rst    = 1'b1;
        drive('0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        wq.delete();
    endtask

    // Monitor: pop and compare whenever the DUT presents a beat or writeback.
    always @(negedge clk) begin
        if (mon_en && mem_we) begin
            if (mq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mem_unexpected actual=%0h required=none",
                         mem_addr);
            end else begin
                beat_t e;
                e = mq.pop_front();
                chk("mem_addr", 128'(mem_addr), 128'(e.a));
                chk("mem_wdata", 128'(mem_wdata), 128'(e.d));
            end
        end
        if (mon_en && regWriteW) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual=%0h required=none", RdW);
            end else begin
                wb_t w;
                w = wq.pop_front();
                chk("wb_rd", 128'(RdW), 128'(w.rd));
                chk("wb_cmp", 128'(compResW), 128'(w.cmp));
                chk("wb_data", {WD3, WD2, WD1, WD0}, w.d);
            end
        end
    end

    initial begin
        int   n;
        ins_t x;
        do_reset();
        @(negedge clk);
        chk("rst_stall", 128'(stall), 0);
        chk("rst_mem_we", 128'(mem_we), 0);
        chk("rst_mem_addr", 128'(mem_addr), 0);
        chk("rst_mem_wdata", 128'(mem_wdata), 0);
        chk("rst_regWriteW", 128'(regWriteW), 0);
        chk("rst_wb", {WD3, WD2, WD1, WD0, 24'd0, RdW, compResW}, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Plain store: 5 cycles at the upstream register, no writeback.
        x = mk(0, 1, 4'd2, 4'h3, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        issue(x, 1, n);
        chk("store_cycles", 128'(n), 5);

        // ALU op: writeback one cycle later.
        x = mk(1, 0, 4'd5, 4'h9, {96'd0, 32'h11});
        issue(x, 1, n);
        chk("alu_cycles", 128'(n), 1);
        drive('0);
        @(negedge clk);
        chk("alu_wb_en", 128'(regWriteW), 1);
        chk("alu_wb_rd", 128'(RdW), 5);
        chk("alu_mem_we", 128'(mem_we), 0);
        chk("alu_stall", 128'(stall), 0);
        @(posedge clk);
        #1;

        // Store+regWrite with wrapping addresses, writeback after flush.
        x = mk(1, 1, 4'd15, 4'h6, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        issue(x, 1, n);
        chk("wrap_cycles", 128'(n), 5);
        drive('0);
        @(negedge clk);
        chk("flush_wb_en", 128'(regWriteW), 0);
        chk("flush_mem_we", 128'(mem_we), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("flush_wb_late", 128'(regWriteW), 1);
        chk("flush_wb_rd", 128'(RdW), 15);
        @(posedge clk);
        #1;

        // Reset in the middle of a store.
        do_reset();
        x = mk(1, 1, 4'd3, 4'h1, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
        drive(x);
        @(negedge clk);
        chk("rs_stall_T", 128'(stall), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rs_we_T1", 128'(mem_we), 1);
        chk("rs_addr_T1", 128'(mem_addr), 16);
        chk("rs_data_T1", 128'(mem_wdata), 32'hE0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive('0);
        @(negedge clk);
        chk("rs_we_T2", 128'(mem_we), 1);
        chk("rs_addr_T2", 128'(mem_addr), 17);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rs_stall_T3", 128'(stall), 0);
        chk("rs_we_T3", 128'(mem_we), 0);
        chk("rs_addr_T3", 128'(mem_addr), 0);
        chk("rs_wb_T3", 128'(regWriteW), 0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Back-to-back stores then an ALU op.
        issue(mk(0, 1, 4'd1, 4'h0, {32'hB3, 32'hB2, 32'hB1, 32'hB0}), 1, n);
        issue(mk(0, 1, 4'd7, 4'h0, {32'hC3, 32'hC2, 32'hC1, 32'hC0}), 1, n);
        issue(mk(1, 0, 4'd9, 4'h2, {32'h4, 32'h3, 32'h2, 32'h1}), 1, n);
        for (int i = 0; i < 4; i++) issue('0, 1, n);
        chk("b2b_mq_empty", 128'(mq.size()), 0);
        chk("b2b_wq_empty", 128'(wq.size()), 0);

        // Random mix of stores, register writes and bubbles.
        for (int i = 0; i < 300; i++) begin
            x.rw  = 1'($urandom_range(0, 1));
            x.mw  = ($urandom_range(0, 2) == 0);
            x.rd  = 4'($urandom);
            x.cmp = 4'($urandom);
            x.d   = {$urandom, $urandom, $urandom, $urandom};
            issue(x, 1, n);
        end
        for (int i = 0; i < 20; i++) issue('0, 1, n);
        chk("rand_mq_empty", 128'(mq.size()), 0);
        chk("rand_wq_empty", 128'(wq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
